// File: rtl/wall_round_controller.sv
// Per-round sequencer for the wall compositing path. Moves the wall toward
// the player one depth step every FRAMES_PER_STEP frames. Once the wall
// reaches the player, it counts wall/player overlap pixels for one full frame,
// grades the round and keeps a saturating score of passed rounds.
//
// Handshake note: this block has no valid/ready channels. frame_start_in is a
// one-cycle event strobe. pixel_valid_in qualifies is_wall_in/is_player_in on
// the same cycle. round_done_out is a one-cycle event strobe, and
// round_pass_out, score_out and wall_color_out are stable while it is high.
module wall_round_controller #(
   parameter int START_DEPTH     = 255,
   parameter int DEPTH_STEP      = 4,
   parameter int FRAMES_PER_STEP = 2,
   parameter int HIT_THRESHOLD   = 64,
   parameter int RESULT_FRAMES   = 60
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        frame_start_in,
   input  logic        start_in,
   input  logic [7:0]  player_depth_in,
   input  logic        pixel_valid_in,
   input  logic        is_wall_in,
   input  logic        is_player_in,
   output logic [7:0]  wall_depth_out,
   output logic [15:0] wall_color_out,
   output logic        wall_active_out,
   output logic        round_done_out,
   output logic        round_pass_out,
   output logic [7:0]  score_out,
   output logic [1:0]  state_out
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_APPROACH = 2'd1;
   localparam logic [1:0] S_CHECK    = 2'd2;
   localparam logic [1:0] S_RESULT   = 2'd3;

   localparam logic [15:0] COLOR_IDLE = 16'h001F;
   localparam logic [15:0] COLOR_PASS = 16'h07E0;
   localparam logic [15:0] COLOR_FAIL = 16'hF800;

   localparam logic [7:0]  START_D    = 8'(START_DEPTH);
   localparam logic [7:0]  STEP_D     = 8'(DEPTH_STEP);
   localparam logic [7:0]  STEP_LAST  = 8'(FRAMES_PER_STEP - 1);
   localparam logic [7:0]  RES_LAST   = 8'(RESULT_FRAMES - 1);
   localparam logic [19:0] HIT_LIMIT  = 20'(HIT_THRESHOLD);

   logic [1:0]  state_q;
   logic [1:0]  state_d;
   logic [7:0]  frame_cnt;
   logic        armed;
   logic [19:0] hits;
   logic [7:0]  next_depth;
   logic        step_now;
   logic        overlap;
   logic        pass;

   // Saturating next depth: the wall never wraps past depth 0.
   assign next_depth = (wall_depth_out > STEP_D) ? (wall_depth_out - STEP_D) : 8'd0;
   assign step_now   = frame_start_in && (frame_cnt == STEP_LAST);
   assign overlap    = pixel_valid_in && is_wall_in && is_player_in;
   assign pass       = (hits < HIT_LIMIT);
   assign state_out  = state_q;

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start_in) state_d = S_APPROACH;
         S_APPROACH: if (step_now && (next_depth <= player_depth_in)) state_d = S_CHECK;
         S_CHECK:    if (frame_start_in && armed) state_d = S_RESULT;
         S_RESULT:   if (frame_start_in && (frame_cnt == RES_LAST)) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // State register and the registered wall-active flag that follows it.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q         <= S_IDLE;
         wall_active_out <= 1'b0;
      end else begin
         state_q         <= state_d;
         wall_active_out <= (state_d == S_APPROACH) || (state_d == S_CHECK);
      end
   end

   // Round datapath: depth stepping, overlap counting, grading and score.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wall_depth_out <= START_D;
         wall_color_out <= COLOR_IDLE;
         round_done_out <= 1'b0;
         round_pass_out <= 1'b0;
         score_out      <= 8'd0;
         frame_cnt      <= 8'd0;
         armed          <= 1'b0;
         hits           <= 20'd0;
      end else begin
         round_done_out <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A frame pulse coincident with start is deliberately dropped.
               if (start_in) begin
                  wall_depth_out <= START_D;
                  wall_color_out <= COLOR_IDLE;
                  frame_cnt      <= 8'd0;
                  round_pass_out <= 1'b0;
               end
            end
            S_APPROACH: begin
               if (frame_start_in) begin
                  if (step_now) begin
                     frame_cnt      <= 8'd0;
                     wall_depth_out <= next_depth;
                     if (next_depth <= player_depth_in) begin
                        hits  <= 20'd0;
                        armed <= 1'b0;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            S_CHECK: begin
               if (frame_start_in) begin
                  if (!armed) begin
                     armed <= 1'b1;
                  end else begin
                     // Close the measured frame; overlap on this cycle is not counted.
                     round_pass_out <= pass;
                     round_done_out <= 1'b1;
                     wall_color_out <= pass ? COLOR_PASS : COLOR_FAIL;
                     frame_cnt      <= 8'd0;
                     if (pass && (score_out != 8'hFF)) score_out <= score_out + 8'd1;
                  end
               end else if (armed && overlap && (hits != 20'hFFFFF)) begin
                  hits <= hits + 20'd1;
               end
            end
            S_RESULT: begin
               if (frame_start_in) begin
                  if (frame_cnt == RES_LAST) begin
                     frame_cnt      <= 8'd0;
                     wall_depth_out <= START_D;
                     wall_color_out <= COLOR_IDLE;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            default: begin
               frame_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wall_round_controller.sv
// Randomized bench for wall_round_controller with a round-level reference
// model and an expected-result queue drained by an independent monitor.
module tb_wall_round_controller;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        frame_start_in = 1'b0;
   logic        start_in = 1'b0;
   logic [7:0]  player_depth_in = 8'd0;
   logic        pixel_valid_in = 1'b0;
   logic        is_wall_in = 1'b0;
   logic        is_player_in = 1'b0;
   logic [7:0]  wall_depth_out;
   logic [15:0] wall_color_out;
   logic        wall_active_out;
   logic        round_done_out;
   logic        round_pass_out;
   logic [7:0]  score_out;
   logic [1:0]  state_out;

   int checks = 0;
   int errors = 0;
   int score_m = 0;
   int last_pass_m = 0;

   // Expected grade record: {pass, score, color, depth}
   logic [32:0] exp_q[$];

   wall_round_controller dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .frame_start_in  (frame_start_in),
      .start_in        (start_in),
      .player_depth_in (player_depth_in),
      .pixel_valid_in  (pixel_valid_in),
      .is_wall_in      (is_wall_in),
      .is_player_in    (is_player_in),
      .wall_depth_out  (wall_depth_out),
      .wall_color_out  (wall_color_out),
      .wall_active_out (wall_active_out),
      .round_done_out  (round_done_out),
      .round_pass_out  (round_pass_out),
      .score_out       (score_out),
      .state_out       (state_out)
   );

   // Clock
   always #5 clk_in = ~clk_in;

   // Monitor: every grade pulse must match the oldest expected record.
   always @(negedge clk_in) begin
      if (!rst_in && round_done_out) begin
         logic [32:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL round_done_unexpected actual=1 required=0 t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            if ({round_pass_out, score_out, wall_color_out, wall_depth_out} !== e) begin
               errors++;
               $display("FAIL round_grade actual=%0h required=%0h t=%0t",
                        {round_pass_out, score_out, wall_color_out, wall_depth_out}, e, $time);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_pix(input bit v, input bit w, input bit p);
      pixel_valid_in = v;
      is_wall_in     = w;
      is_player_in   = p;
   endtask

   task automatic frame_pulse(input bit ov);
      frame_start_in = 1'b1;
      set_pix(ov, ov, ov);
      tick();
      frame_start_in = 1'b0;
      set_pix(0, 0, 0);
   endtask

   // Drive n_ov overlap cycles interleaved with n_noise near-miss pixels.
   task automatic pixels(input int n_ov, input int n_noise);
      int ov_left = n_ov;
      int nz_left = n_noise;
      while (ov_left + nz_left > 0) begin
         if (nz_left == 0 || (ov_left > 0 && $urandom_range(0, 1) == 1)) begin
            set_pix(1, 1, 1);
            ov_left--;
         end else begin
            case ($urandom_range(0, 2))
               0:       set_pix(0, 1, 1);
               1:       set_pix(1, 1, 0);
               default: set_pix(1, 0, 1);
            endcase
            nz_left--;
         end
         tick();
      end
      set_pix(0, 0, 0);
   endtask

   // Reference: number of depth steps to reach the player and the depth then.
   function automatic int model_steps(input int pd);
      int diff = 255 - pd;
      if (diff <= 0) return 1;
      return (diff + 3) / 4;
   endfunction

   function automatic int model_depth(input int pd);
      int d = 255 - 4 * model_steps(pd);
      return (d < 0) ? 0 : d;
   endfunction

   task automatic start_round(input int pd, input bit with_frame);
      player_depth_in = 8'(pd);
      start_in        = 1'b1;
      frame_start_in  = with_frame;
      tick();
      start_in        = 1'b0;
      frame_start_in  = 1'b0;
      last_pass_m     = 0;
      chk("start_state", 32'(state_out), 32'd1);
      chk("start_depth", 32'(wall_depth_out), 32'd255);
      chk("start_active", 32'(wall_active_out), 32'd1);
   endtask

   task automatic approach(input int pd, input bit fast);
      int k = model_steps(pd);
      for (int i = 0; i < 2 * k; i++) begin
         if (i == 2 * k - 1) chk("approach_hold", 32'(state_out), 32'd1);
         frame_pulse(fast ? 1'b0 : 1'($urandom_range(0, 1)));
         if (!fast) repeat ($urandom_range(0, 2)) tick();
      end
      chk("check_state", 32'(state_out), 32'd2);
      chk("check_depth", 32'(wall_depth_out), 32'(model_depth(pd)));
   endtask

   task automatic run_round(input int pd, input int nhits, input bit noisy, input bit fast);
      bit p;
      int sc;
      start_round(pd, noisy);
      approach(pd, fast);
      if (noisy) pixels($urandom_range(1, 20), $urandom_range(0, 5));
      frame_pulse(noisy);
      pixels(nhits, fast ? 0 : $urandom_range(0, 30));
      p  = (nhits < 64);
      sc = (p && score_m < 255) ? score_m + 1 : score_m;
      exp_q.push_back({p, 8'(sc), (p ? 16'h07E0 : 16'hF800), 8'(model_depth(pd))});
      frame_pulse(noisy);
      score_m     = sc;
      last_pass_m = p;
      chk("result_state", 32'(state_out), 32'd3);
      chk("result_active", 32'(wall_active_out), 32'd0);
      for (int i = 0; i < 59; i++) begin
         frame_pulse(1'b0);
         if (!fast && i == 20) begin
            start_in = 1'b1;
            tick();
            start_in = 1'b0;
         end
      end
      chk("result_hold", 32'(state_out), 32'd3);
      frame_pulse(1'b0);
      chk("idle_state", 32'(state_out), 32'd0);
      chk("idle_depth", 32'(wall_depth_out), 32'd255);
      chk("idle_color", 32'(wall_color_out), 32'h001F);
      chk("idle_score", 32'(score_out), 32'(score_m));
      chk("idle_pass", 32'(round_pass_out), 32'(last_pass_m));
   endtask

   initial begin
      // Reset
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      chk("rst_state", 32'(state_out), 32'd0);
      chk("rst_depth", 32'(wall_depth_out), 32'd255);
      chk("rst_color", 32'(wall_color_out), 32'h001F);
      chk("rst_active", 32'(wall_active_out), 32'd0);
      chk("rst_done", 32'(round_done_out), 32'd0);
      chk("rst_score", 32'(score_out), 32'd0);

      // Directed: pass at 63, fail at 64 with ignored overlap, wall down to 0
      run_round(200, 63, 1'b0, 1'b0);
      run_round(200, 64, 1'b1, 1'b0);
      run_round(0, 10, 1'b1, 1'b0);
      run_round(252, 0, 1'b0, 1'b0);

      // Randomized rounds
      for (int r = 0; r < 8; r++)
         run_round($urandom_range(0, 255), $urandom_range(40, 90), 1'b1, 1'b0);

      // Reset in the middle of CHECK aborts the round and clears the score
      start_round(240, 1'b0);
      approach(240, 1'b1);
      frame_pulse(1'b0);
      pixels(5, 3);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      score_m = 0;
      last_pass_m = 0;
      chk("midrst_state", 32'(state_out), 32'd0);
      chk("midrst_depth", 32'(wall_depth_out), 32'd255);
      chk("midrst_color", 32'(wall_color_out), 32'h001F);
      chk("midrst_active", 32'(wall_active_out), 32'd0);
      chk("midrst_pass", 32'(round_pass_out), 32'd0);
      chk("midrst_score", 32'(score_out), 32'd0);

      // Score saturation
      while (score_m < 255) run_round(255, $urandom_range(0, 3), 1'b0, 1'b1);
      run_round(255, 1, 1'b0, 1'b1);
      chk("score_sat", 32'(score_out), 32'd255);

      repeat (3) tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wall_round_controller.md
Name: wall_round_controller

Overview:
- Per-round game sequencer for the wall compositing path.
- Steps the wall toward the player once per N frames and drives the compositor's wall_depth and wall_color.
- When the wall reaches the player's depth, counts wall/player overlap pixels for one full frame, grades the round pass/fail and keeps the score.
- Sits between frame timing, player segmentation and the graphics compositor.

Parameters:
START_DEPTH, 255, wall depth loaded at round start and in IDLE
DEPTH_STEP, 4, depth decrement per step
FRAMES_PER_STEP, 2, frame_start pulses per depth step (>=1)
HIT_THRESHOLD, 64, round passes iff overlap count < this
RESULT_FRAMES, 60, frame_start pulses spent in RESULT before IDLE

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
frame_start_in  input  1  one-cycle pulse at start of each frame
start_in  input  1  start-round request, sampled only in IDLE
player_depth_in  input  8  current player depth
pixel_valid_in  input  1  active-pixel qualifier for the overlap inputs
is_wall_in  input  1  current pixel is wall
is_player_in  input  1  current pixel is player
wall_depth_out  output  8  depth to compositor
wall_color_out  output  16  RGB565 wall color to compositor
wall_active_out  output  1  high in APPROACH and CHECK
round_done_out  output  1  one-cycle pulse when round is graded
round_pass_out  output  1  grade of last round
score_out  output  8  passed-round count, saturating
state_out  output  2  IDLE=0, APPROACH=1, CHECK=2, RESULT=3

Behaviour:
- Reset: state IDLE; wall_depth_out=START_DEPTH; wall_color_out=16'h001F; wall_active_out=0; round_done_out=0; round_pass_out=0; score_out=0; internal counters=0. Reset mid-round aborts the round and clears the score.
- All outputs are registered. State changes take effect the cycle after the triggering input.
- IDLE:
  - start_in=1 -> APPROACH.
  - Load wall_depth=START_DEPTH, frame_cnt=0, round_pass_out=0, wall_color=16'h001F.
  - A frame_start_in coincident with start_in is not counted.
- APPROACH:
  - Each frame_start_in increments frame_cnt.
  - When frame_cnt==FRAMES_PER_STEP-1 on a pulse: frame_cnt<=0 and wall_depth<=next_depth, where next_depth = (wall_depth>DEPTH_STEP) ? wall_depth-DEPTH_STEP : 0 (saturating, never wraps).
  - If next_depth <= player_depth_in on that same step -> CHECK. Hit counter cleared and armed=0.
- CHECK:
  - wall_depth holds.
  - First frame_start_in sets armed=1.
  - While armed, each cycle with pixel_valid_in & is_wall_in & is_player_in increments the 20-bit hit counter, saturating at 2^20-1. Pixels before arming are ignored.
  - Next frame_start_in while armed -> RESULT.
  - The overlap term on that same cycle is excluded.
  - pass = (hits < HIT_THRESHOLD).
- Entering RESULT, on the same edge:
  - round_pass_out<=pass; round_done_out<=1 for exactly one cycle.
  - score_out<=score+1 on pass, holding at 255.
  - wall_color_out<=16'h07E0 on pass, 16'hF800 on fail.
  - frame_cnt<=0.
- RESULT:
  - Count frame_start_in pulses. On pulse number RESULT_FRAMES -> IDLE.
  - On that transition: wall_depth<=START_DEPTH, wall_color<=16'h001F.
  - round_pass_out and score_out hold.
- start_in is ignored outside IDLE.
- If player_depth_in >= START_DEPTH-DEPTH_STEP, the first step enters CHECK.
- If player_depth_in changes mid-APPROACH, only the value sampled at step instants matters.

Test Plan:
- Reset, then start_in=1 -> APPROACH next cycle, wall_depth_out=255, wall_active_out=1.
- player_depth_in=200, 2 frame_start pulses per step -> depth 251,247,...,199. Enters CHECK on the step producing 199 after 28 pulses.
- CHECK frame with 63 overlap pixels -> round_done_out one-cycle pulse, round_pass_out=1, score_out=1, wall_color_out=16'h07E0. After 60 frame_start pulses -> IDLE, wall_depth_out=255.
- 64 overlap pixels, plus overlap asserted before arming and on the closing frame_start cycle -> fail: round_pass_out=0, score_out unchanged, wall_color_out=16'hF800.
- Preload 255 passes, then one more pass -> score_out stays 255. DEPTH_STEP=4 with depth 3 and player_depth_in=0 -> next depth 0, no wrap, enters CHECK.
- rst_in asserted mid-CHECK -> next cycle all outputs at reset values, state_out=0. start_in during RESULT is ignored.
